// File: rtl/simd_alu_issue_pkg.sv
// Shared types for the SIMD ALU issue stage: opcodes, command record,
// issue FSM states and the add/sub classifier used for flag masking.
package simd_alu_issue_pkg;

  localparam int SIMD_DATA_WIDTH = 256;
  localparam int SIMD_OPC_WIDTH  = 5;
  localparam int ISSUE_TAG_WIDTH = 4;

  typedef logic [SIMD_OPC_WIDTH-1:0] opc_t;

  localparam opc_t OP_ADD8    = 5'd0;
  localparam opc_t OP_ADD16   = 5'd1;
  localparam opc_t OP_ADD32   = 5'd2;
  localparam opc_t OP_S_ADD8  = 5'd3;
  localparam opc_t OP_S_ADD16 = 5'd4;
  localparam opc_t OP_S_ADD32 = 5'd5;
  localparam opc_t OP_SUB8    = 5'd6;
  localparam opc_t OP_SUB16   = 5'd7;
  localparam opc_t OP_SUB32   = 5'd8;
  localparam opc_t OP_S_SUB8  = 5'd9;
  localparam opc_t OP_S_SUB16 = 5'd10;
  localparam opc_t OP_S_SUB32 = 5'd11;
  localparam opc_t OP_AND     = 5'd12;
  localparam opc_t OP_OR      = 5'd13;
  localparam opc_t OP_XOR     = 5'd14;
  localparam opc_t OP_LSL8    = 5'd15;
  localparam opc_t OP_LSR8    = 5'd16;

  typedef struct packed {
    opc_t                       opcode;
    logic [SIMD_DATA_WIDTH-1:0] a;
    logic [SIMD_DATA_WIDTH-1:0] b;
    logic [ISSUE_TAG_WIDTH-1:0] tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXEC
  } issue_state_t;

  function automatic logic is_addsub(input opc_t opc);
    return opc inside {
      OP_ADD8, OP_ADD16, OP_ADD32,
      OP_S_ADD8, OP_S_ADD16, OP_S_ADD32,
      OP_SUB8, OP_SUB16, OP_SUB32,
      OP_S_SUB8, OP_S_SUB16, OP_S_SUB32
    };
  endfunction

endpackage

// File: rtl/simd_alu_issue_if.sv
// Command and result valid/ready channels of the issue stage.
// master: command producer / result consumer; slave: issue stage.
interface simd_alu_issue_if #(
  parameter int DW = 256,
  parameter int OW = 5,
  parameter int TW = 4
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [OW-1:0] cmd_opcode;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [TW-1:0] cmd_tag;

  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic [DW/8-1:0] res_ovf;
  logic [DW/8-1:0] res_udf;
  logic [TW-1:0]   res_tag;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a,
    output cmd_b, cmd_tag, res_ready,
    input  cmd_ready, res_valid, res_data,
    input  res_ovf, res_udf, res_tag
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a,
    input  cmd_b, cmd_tag, res_ready,
    output cmd_ready, res_valid, res_data,
    output res_ovf, res_udf, res_tag
  );

endinterface

// File: rtl/simd_alu_cmd_fifo.sv
// Command FIFO: W-bit entries, D deep (power of two), strict order.
// Ports: clk, rst, push/din, pop/dout, full, empty (from occupancy).
module simd_alu_cmd_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // pointers wrap naturally because D is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(D));
  assign empty = (count == '0);

endmodule

// File: rtl/simd_alu_issue.sv
// Issue/writeback stage around the SIMD ALU: buffers commands, holds
// operands and opcode across the ALU's two-cycle window, returns results.
// Ports: clk, rst, io (cmd/res channels), alu_* (ALU side), busy,
// done_count (result handshakes, wrapping).
module simd_alu_issue
  import simd_alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = SIMD_DATA_WIDTH,
  parameter int OPC_WIDTH  = SIMD_OPC_WIDTH,
  parameter int TAG_WIDTH  = ISSUE_TAG_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  simd_alu_issue_if.slave         io,
  output logic [DATA_WIDTH-1:0]   alu_a,
  output logic [DATA_WIDTH-1:0]   alu_b,
  output logic [OPC_WIDTH-1:0]    alu_opcode,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  input  logic [DATA_WIDTH/8-1:0] alu_ovf,
  input  logic [DATA_WIDTH/8-1:0] alu_udf,
  output logic                    busy,
  output logic [15:0]             done_count
);

  issue_state_t state;
  issue_state_t state_n;
  alu_cmd_t     op_q;
  alu_cmd_t     fifo_din;
  alu_cmd_t     fifo_dout;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         res_hs;

  logic                    res_valid_q;
  logic [DATA_WIDTH-1:0]   res_data_q;
  logic [DATA_WIDTH/8-1:0] res_ovf_q;
  logic [DATA_WIDTH/8-1:0] res_udf_q;
  logic [TAG_WIDTH-1:0]    res_tag_q;

  assign fifo_din = '{
    opcode: io.cmd_opcode,
    a:      io.cmd_a,
    b:      io.cmd_b,
    tag:    io.cmd_tag
  };

  assign push = io.cmd_valid && !full;

  simd_alu_cmd_fifo #(
    .W ($bits(alu_cmd_t)),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign res_hs = res_valid_q && io.res_ready;

  // a pop is only allowed when the result slot is free or being drained
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && (!res_valid_q || io.res_ready)) begin
          pop     = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD:    state_n = EXEC;
      EXEC:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= '0;
      res_udf_q   <= '0;
      res_tag_q   <= '0;
      done_count  <= '0;
    end else begin
      state <= state_n;
      if (pop) op_q <= fifo_dout;
      if (state == EXEC) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu_out;
        res_tag_q   <= op_q.tag;
        res_ovf_q   <= is_addsub(op_q.opcode) ? alu_ovf : '0;
        res_udf_q   <= is_addsub(op_q.opcode) ? alu_udf : '0;
      end else if (res_hs) begin
        res_valid_q <= 1'b0;
      end
      if (res_hs) done_count <= done_count + 1'b1;
    end
  end

  // ALU inputs come straight from the op register so they hold between ops
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign alu_opcode = op_q.opcode;

  assign io.cmd_ready = !full;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign io.res_ovf   = res_ovf_q;
  assign io.res_udf   = res_udf_q;
  assign io.res_tag   = res_tag_q;

  assign busy = (state != IDLE) || !empty;

endmodule

// File: doc/simd_alu_issue.md
Name: simd_alu_issue

Overview:
- Issue/writeback stage wrapped around simd_alu_top.
- Accepts ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Sequences each command through the ALU's registered-input timing and returns the result, lane flags and tag over a valid/ready result interface.
- Guarantees opcode stability across the ALU's two-cycle operand/select window, which the ALU itself does not enforce.

Parameters:
- DATA_WIDTH, 256, SIMD vector width; must match SIMD_DATA_WIDTH.
- OPC_WIDTH, SIMD_OPC_WIDTH, opcode width.
- TAG_WIDTH, 4, opaque command tag width.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_opcode  in  OPC_WIDTH  ALU opcode.
- cmd_a  in  DATA_WIDTH  operand A.
- cmd_b  in  DATA_WIDTH  operand B.
- cmd_tag  in  TAG_WIDTH  returned with result.
- alu_a  out  DATA_WIDTH  to ALU in_a.
- alu_b  out  DATA_WIDTH  to ALU in_b.
- alu_opcode  out  OPC_WIDTH  to ALU opcode.
- alu_out  in  DATA_WIDTH  from ALU out.
- alu_ovf  in  DATA_WIDTH/8  from ALU out_overflow.
- alu_udf  in  DATA_WIDTH/8  from ALU out_underflow.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts.
- res_data  out  DATA_WIDTH  result vector.
- res_ovf  out  DATA_WIDTH/8  per-byte overflow.
- res_udf  out  DATA_WIDTH/8  per-byte underflow.
- res_tag  out  TAG_WIDTH  tag of result.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- done_count  out  16  completed results handed off; wraps at 0xFFFF→0.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values: all outputs 0 except cmd_ready=1. FIFO is emptied, FSM goes to IDLE, op register (a, b, opcode, tag) is cleared.
- Reset mid-operation: any in-flight op is discarded and no res_valid is produced for it.
- FIFO push: on cmd_valid && cmd_ready.
- cmd_ready: = !full, registered from occupancy.
  - No bypass: a full FIFO stays non-ready in the cycle it is popped.
  - Ready reasserts on the following cycle.
- FIFO ordering: strict, no reordering. Pointer wrap at FIFO_DEPTH.
- FSM states IDLE, LOAD, EXEC.
  - IDLE → LOAD when fifo non-empty && (!res_valid || res_ready). The pop loads the op register.
  - LOAD: alu_a/alu_b/alu_opcode = op register. The ALU captures operands and data mode at the end of this cycle.
  - EXEC: alu_opcode is still held unchanged, so the ALU's combinational result select stays valid. At the end of the cycle, capture alu_out, flags and tag into the result register and set res_valid; → IDLE.
- alu_* ports always reflect the op register and hold their value when idle.
- Latency and throughput:
  - Accepting edge E0, pop at E1, ALU capture at E2, result capture at E3.
  - res_valid is high after E3.
  - Sustained throughput is 1 op per 3 cycles.
- Result handshake:
  - res_valid stays high, and res_* stay stable, until res_valid && res_ready.
  - Handshake and a new pop in the same IDLE cycle are legal.
  - res_valid clears at that edge unless a new capture sets it; capture can only occur 2 edges later.
- Flag masking:
  - res_ovf/res_udf = alu flags only when the opcode is an add/sub (ADD*, S_ADD*, SUB*, S_SUB*).
  - Otherwise both are forced to 0.
- done_count increments on each result handshake.

Decomposition:
- Shared package (extends simd_alu_defines):
  - Opcode constants.
  - Function is_addsub(opcode).
  - Typedef alu_cmd_t {opcode, a, b, tag}.
  - Typedef issue_state_t {IDLE, LOAD, EXEC}.
- One sub-module: simd_alu_cmd_fifo, parameterised width/depth, with full/empty outputs.

Test Plan:
- Reset: assert rst 2 cycles → cmd_ready=1, res_valid=0, alu_a=0, done_count=0, busy=0.
- ADD8 latency: a=all 0x01, b=all 0x02, tag=5, res_ready=1.
  - res_valid rises exactly 3 edges after accept.
  - res_data=all 0x03, res_ovf=0, res_tag=5, done_count=1.
- Flags: S_ADD8 with a byte0=0x7F, b byte0=0x01 → res_data byte0=0x80, res_ovf[0]=1.
  - Same operands with LSL8 → res_ovf=0, res_udf=0.
- Backpressure: res_ready=0, offer tags 1..6 back-to-back.
  - Tags 1..5 accepted; cmd_ready=0 after the 5th.
  - Result tag 1 held stable; FSM stays IDLE.
  - Release res_ready → tags returned in order 1..6.
- Opcode hold: in EXEC, alu_opcode equals the LOAD-cycle value even while cmd_opcode changes every cycle.
- Reset in EXEC: assert rst during EXEC → no res_valid ever for that op, FIFO empty, cmd_ready=1 next cycle.
